// File: rtl/uart_pkg.sv
// Shared encodings for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmit FSM states.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; push lands on the next edge, dout shows the head combinationally.
// A push while full is accepted only when a pop happens in the same cycle, otherwise dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: only entries behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-store-driven UART transmitter: bytes written to TXDATA are queued and sent as 8N1 frames.
// tx falls two edges after a store into an idle empty queue; stores to a full queue are dropped and flag overflow.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ovf_q, ovf_d;

    logic [1:0]           offset;
    logic                 wr_txdata, wr_ctrl, pop, tick;
    logic [7:0]           fifo_dout;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 unused_bits;

    assign offset      = Mem_WrAddr[3:2];
    assign sel         = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata   = MemWrite && sel && (offset == REG_TXDATA);
    assign wr_ctrl     = MemWrite && sel && (offset == REG_CTRL);
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign tick        = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx          = tx_q;
    assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (Mem_WrData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = START;
                    shift_d = fifo_dout;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx is driven from the next state so the pin itself comes straight from a flop.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Overflow set takes priority over a CTRL clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ctrl && Mem_WrData[0])           ovf_d = 1'b0;
        if (wr_txdata && fifo_full && !pop)     ovf_d = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        if (sel && offset == REG_STATUS) begin
            rd_data[ST_FULL]                   = fifo_full;
            rd_data[ST_EMPTY]                  = fifo_empty;
            rd_data[ST_BUSY]                   = (state_q != IDLE);
            rd_data[ST_OVF]                    = ovf_q;
            rd_data[ST_CNT_LSB+3:ST_CNT_LSB]   = 4'(fifo_count);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench: stores push expected bytes to a scoreboard, a serial monitor decodes tx frames and compares.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam int          CPB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Mem_WrAddr = BASE + 32'h4;
    logic [31:0] Mem_WrData = '0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .DEPTH        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .sel        (sel),
        .rd_data    (rd_data),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int frames = 0;
    bit in_frame = 1'b0;
    logic [7:0] exp_q[$];
    int starts[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite = 1'b1; Mem_WrAddr = a; Mem_WrData = d;
        @(negedge clk);
        MemWrite = 1'b0; Mem_WrAddr = BASE + 32'h4;
    endtask

    task automatic status_is(input string name, input logic [31:0] exp);
        Mem_WrAddr = BASE + 32'h4;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || in_frame) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain_timeout"}, 32'(k >= 3000), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Serial monitor: samples every negedge, each bit must hold for CPB samples.
    initial begin : monitor
        logic [9:0] bits;
        bit aborted;
        bits = '0;
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                in_frame = 1'b1;
                aborted  = 1'b0;
                starts.push_back(cycle);
                for (int i = 0; i < 10 * CPB && !aborted; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!reset) aborted = 1'b1;
                    else if (i % CPB == 0) bits[i / CPB] = tx;
                    else check("bit_hold", 32'(tx), 32'(bits[i / CPB]));
                end
                if (!aborted) begin
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h, expected no frame", bits[8:1]);
                    end else begin
                        check("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                    end
                    frames++;
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int f0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        status_is("reset_status", 32'h2);
        check("sel_in_window", 32'(sel), 32'd1);

        // Single byte: latency and bit pattern.
        exp_q.push_back(8'h55);
        store(BASE, 32'hABCD_EF55);
        check("lat_edge1_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_edge2_tx", 32'(tx), 32'd0);
        status_is("busy_status", 32'h6);
        drain("single");
        status_is("idle_status", 32'h2);

        // Six back-to-back stores: five accepted, sixth dropped.
        starts.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 6; i++) begin
            MemWrite = 1'b1; Mem_WrAddr = BASE; Mem_WrData = 32'(i);
            @(negedge clk);
        end
        MemWrite = 1'b0;
        status_is("overflow_full_status", 32'h4D);
        drain("burst");
        check("burst_frame_count", 32'(starts.size()), 32'd5);
        for (int i = 1; i < 5 && i < starts.size(); i++)
            check("frame_spacing", 32'(starts[i] - starts[i-1]), 32'd41);
        status_is("after_burst_status", 32'hA);

        // Overflow clear via CTRL.
        store(BASE + 32'h8, 32'h0);
        status_is("ctrl_zero_keeps_ovf", 32'hA);
        store(BASE + 32'h8, 32'h1);
        status_is("ctrl_clear", 32'h2);
        for (int i = 7; i <= 11; i++) exp_q.push_back(8'(i));
        for (int i = 7; i <= 12; i++) begin
            MemWrite = 1'b1; Mem_WrAddr = BASE; Mem_WrData = 32'(i);
            @(negedge clk);
        end
        MemWrite = 1'b0;
        store(BASE + 32'h8, 32'h1);
        status_is("cleared_while_full", 32'h45);
        store(BASE, 32'hEE);
        status_is("ovf_set_again", 32'h4D);
        drain("refill");
        store(BASE + 32'h8, 32'h1);
        status_is("ovf_cleared", 32'h2);

        // Reset during DATA of 0xA3 with two bytes queued.
        for (int i = 0; i < 3; i++) begin
            MemWrite = 1'b1; Mem_WrAddr = BASE;
            Mem_WrData = (i == 0) ? 32'hA3 : (i == 1) ? 32'h11 : 32'h22;
            @(negedge clk);
        end
        MemWrite = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1 check("async_reset_tx", 32'(tx), 32'd1);
        status_is("in_reset_status", 32'h2);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        status_is("post_reset_status", 32'h2);
        f0 = frames;
        repeat (100) @(negedge clk);
        check("no_frames_after_reset", 32'(frames), 32'(f0));
        check("idle_tx_after_reset", 32'(tx), 32'd1);

        // Stores outside the window and to the reserved offset.
        @(negedge clk);
        MemWrite = 1'b1; Mem_WrAddr = BASE + 32'h10; Mem_WrData = 32'hFF;
        #1 check("sel_outside", 32'(sel), 32'd0);
        @(negedge clk);
        Mem_WrAddr = BASE + 32'hC;
        #1 check("sel_reserved", 32'(sel), 32'd1);
        check("reserved_read", rd_data, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0; Mem_WrAddr = BASE;
        #1 check("txdata_read", rd_data, 32'h0);
        status_is("no_fifo_change", 32'h2);
        f0 = frames;
        repeat (20) @(negedge clk);
        check("no_frame_from_ignored", 32'(frames), 32'(f0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
